// File: rtl/combo_checker_if.sv
// combo_checker_if: switch/strobe inputs and match/status outputs between lock FSM and combo_checker
interface combo_checker_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] SW;
  logic savePW, saveAT, M, PW_SET, LOCKOUT;
  logic [3:0] FAIL_COUNT;
  modport master (output SW, savePW, saveAT, input M, PW_SET, LOCKOUT, FAIL_COUNT);
  modport slave (input SW, savePW, saveAT, output M, PW_SET, LOCKOUT, FAIL_COUNT);
endinterface

// File: rtl/combo_checker.sv
// combo_checker: password store/comparator with failed-attempt lockout; MASTER_CODE_EN adds an override code
module combo_checker #(
  parameter int WIDTH = 4,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYCLES = 250000000,
  parameter logic [WIDTH-1:0] MASTER_CODE = 4'hA
) (
  input logic CLK50,
  input logic reset,
  combo_checker_if.slave bus
);
  localparam int CW = $clog2(LOCKOUT_CYCLES + 1);
  logic [WIDTH-1:0] pw_q, pw_d, at_q, at_d;
  logic pw_set_q, pw_set_d, lock_q, lock_d, sat_q, sat_d;
  logic match, eval, trip, expire;
  logic [3:0] fail_q, fail_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef MASTER_CODE_EN
  assign match = ~lock_q & ((pw_set_q & (at_q == pw_q)) | (at_q == MASTER_CODE));
`else
  logic unused_master;
  assign unused_master = ^MASTER_CODE;
  assign match = pw_set_q & ~lock_q & (at_q == pw_q);
`endif
  assign eval = sat_q & ~bus.saveAT & ~lock_q;
  assign trip = eval & ~match & (({1'b0, fail_q} + 5'd1) >= 5'(MAX_FAIL));
  assign expire = lock_q & (cnt_q == '0);
  // a cycle where savePW wins is not an attempt, so it must not arm the falling-edge evaluation
  always_comb begin
    pw_d = bus.savePW ? bus.SW : pw_q;
    pw_set_d = pw_set_q | bus.savePW;
    at_d = (bus.saveAT & ~bus.savePW & ~lock_q) ? bus.SW : at_q;
    sat_d = bus.saveAT & ~bus.savePW;
    lock_d = lock_q ? ~expire : trip;
    cnt_d = lock_q ? (expire ? '0 : cnt_q - CW'(1)) : (trip ? CW'(LOCKOUT_CYCLES - 1) : cnt_q);
    fail_d = expire ? 4'd0 : trip ? 4'(MAX_FAIL) : eval ? (match ? 4'd0 : fail_q + 4'd1) : fail_q;
  end
  always_ff @(posedge CLK50) begin
    if (reset) begin
      pw_q <= '0;
      at_q <= '0;
      pw_set_q <= 1'b0;
      lock_q <= 1'b0;
      sat_q <= 1'b0;
      fail_q <= 4'd0;
      cnt_q <= '0;
    end else begin
      pw_q <= pw_d;
      at_q <= at_d;
      pw_set_q <= pw_set_d;
      lock_q <= lock_d;
      sat_q <= sat_d;
      fail_q <= fail_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.M = match;
  assign bus.PW_SET = pw_set_q;
  assign bus.LOCKOUT = lock_q;
  assign bus.FAIL_COUNT = fail_q;
endmodule

// File: tb/tb_combo_checker.sv
// tb_combo_checker: table-driven scoreboard bench for combo_checker (MAX_FAIL=3, LOCKOUT_CYCLES=8)
module tb_combo_checker;
  typedef struct { logic m, pwset, lock; logic [3:0] fail; } exp_t;
  typedef struct { logic [3:0] sw; logic spw, sat; exp_t e; } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t tbl[$];
  combo_checker_if #(.WIDTH(4)) bus();
  combo_checker #(.WIDTH(4), .MAX_FAIL(3), .LOCKOUT_CYCLES(8), .MASTER_CODE(4'hA)) dut (
    .CLK50(clk), .reset(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic exp_t ex(logic m, logic ps, logic lk, logic [3:0] f);
    exp_t e;
    e.m = m; e.pwset = ps; e.lock = lk; e.fail = f;
    return e;
  endfunction
  function automatic vec_t v(logic [3:0] sw, logic spw, logic sat, logic m, logic ps, logic lk, logic [3:0] f);
    vec_t r;
    r.sw = sw; r.spw = spw; r.sat = sat; r.e = ex(m, ps, lk, f);
    return r;
  endfunction
  task automatic chk(string name, logic [3:0] act, logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask
  task automatic step(string tag, logic r, logic [3:0] sw, logic spw, logic sat, exp_t e);
    exp_t x;
    @(negedge clk);
    rst = r; bus.SW = sw; bus.savePW = spw; bus.saveAT = sat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".M"}, {3'b0, bus.M}, {3'b0, x.m});
    chk({tag, ".PW_SET"}, {3'b0, bus.PW_SET}, {3'b0, x.pwset});
    chk({tag, ".LOCKOUT"}, {3'b0, bus.LOCKOUT}, {3'b0, x.lock});
    chk({tag, ".FAIL_COUNT"}, bus.FAIL_COUNT, x.fail);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) tbl.push_back(v(4'h5, 1, 0, 0, 1, 0, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(v(4'h5, 0, 1, 1, 1, 0, 0));
    tbl.push_back(v(4'h0, 0, 0, 1, 1, 0, 0));
    for (int a = 0; a < 3; a++) begin
      tbl.push_back(v(4'h3, 0, 1, 0, 1, 0, 4'(a)));
      tbl.push_back(v(4'h3, 0, 1, 0, 1, 0, 4'(a)));
      tbl.push_back(v(4'h3, 0, 0, 0, 1, a == 2, 4'(a + 1)));
    end
    for (int i = 0; i < 2; i++) tbl.push_back(v(4'h5, 0, 1, 0, 1, 1, 3));
    for (int i = 0; i < 5; i++) tbl.push_back(v(4'h0, 0, 0, 0, 1, 1, 3));
    tbl.push_back(v(4'h0, 0, 0, 0, 1, 0, 0));
    for (int a = 0; a < 2; a++) begin
      tbl.push_back(v(4'h3, 0, 1, 0, 1, 0, 4'(a)));
      tbl.push_back(v(4'h3, 0, 1, 0, 1, 0, 4'(a)));
      tbl.push_back(v(4'h3, 0, 0, 0, 1, 0, 4'(a + 1)));
    end
    tbl.push_back(v(4'h5, 0, 1, 1, 1, 0, 2));
    tbl.push_back(v(4'h5, 0, 1, 1, 1, 0, 2));
    tbl.push_back(v(4'h5, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(4'h9, 1, 1, 0, 1, 0, 0));
    tbl.push_back(v(4'h9, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(4'h9, 0, 1, 1, 1, 0, 0));
    tbl.push_back(v(4'h9, 0, 0, 1, 1, 0, 0));
    bus.SW = 4'h0; bus.savePW = 1'b0; bus.saveAT = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.SW = 4'($urandom); bus.savePW = 1'($urandom); bus.saveAT = 1'($urandom);
    end
    step("rst0", 1, 4'h7, 1, 1, ex(0, 0, 0, 0));
    step("rst1", 1, 4'h7, 1, 1, ex(0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("tbl%0d", i), 0, tbl[i].sw, tbl[i].spw, tbl[i].sat, tbl[i].e);
    for (int a = 0; a < 3; a++) begin
      step("lk_at", 0, 4'h3, 0, 1, ex(0, 1, 0, 4'(a)));
      step("lk_ev", 0, 4'h3, 0, 0, ex(0, 1, a == 2, 4'(a + 1)));
    end
    step("lk_pw", 0, 4'h3, 1, 0, ex(0, 1, 1, 3));
    step("lk_rst", 1, 4'h0, 0, 0, ex(0, 0, 0, 0));
`ifdef MASTER_CODE_EN
    step("mc_at", 0, 4'hA, 0, 1, ex(1, 0, 0, 0));
    step("mc_ev", 0, 4'hA, 0, 0, ex(1, 0, 0, 0));
`else
    step("nopw_at", 0, 4'hA, 0, 1, ex(0, 0, 0, 0));
    step("nopw_ev", 0, 4'hA, 0, 0, ex(0, 0, 0, 1));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
